// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 32-bit core.
// Owns the PC and issues word reads to instruction memory over a req/valid
// handshake. Each fetched word is held in an instruction register that
// drives the decoder. The decoder's stall, halt and redirect results stop,
// hold or retarget the fetch.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     read request (held until imem_valid), word address
//   imem_rdata/valid  read data and completion strobe
//   stall             decoder not ready; holds the current instruction
//   halt              held instruction is HALT (sampled at accept)
//   redirect_valid/pc taken branch / PC write and its target
//   instr/instr_valid/instr_pc  instruction register, live flag, its address
//   halted            fetch permanently stopped until reset
//   fetch_count       accepted-instruction counter
//
// Optional feature: define FETCH_COUNT_EN to build the fetch_count counter;
// without it fetch_count is tied to zero.
module instr_fetch #(
    parameter int unsigned         ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        REQ_START,
        REQ,
        HOLD,
        HALTED
    } stateT;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic              reqQ, reqNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic [31:0]       instrQ, instrNext;
    logic              validQ, validNext;
    logic [ADDR_W-1:0] instrPcQ, instrPcNext;
    logic              haltedQ, haltedNext;
    // Set when a redirect arrives while a read is still outstanding; the
    // eventual response is then stale and must be dropped.
    logic              squash, squashNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ_START;
            pc       <= RESET_PC;
            reqQ     <= 1'b0;
            addrQ    <= RESET_PC;
            instrQ   <= '0;
            validQ   <= 1'b0;
            instrPcQ <= RESET_PC;
            haltedQ  <= 1'b0;
            squash   <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            reqQ     <= reqNext;
            addrQ    <= addrNext;
            instrQ   <= instrNext;
            validQ   <= validNext;
            instrPcQ <= instrPcNext;
            haltedQ  <= haltedNext;
            squash   <= squashNext;
        end
    end

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        reqNext     = reqQ;
        addrNext    = addrQ;
        instrNext   = instrQ;
        validNext   = validQ;
        instrPcNext = instrPcQ;
        haltedNext  = haltedQ;
        squashNext  = squash;

        case (state)
            REQ_START: begin
                stateNext = REQ;
                reqNext   = 1'b1;
                addrNext  = pc;
            end
            REQ: begin
                if (imem_valid) begin
                    if (squash || redirect_valid) begin
                        // Stale response: drop it and re-issue at the target.
                        squashNext = 1'b0;
                        if (redirect_valid) begin
                            pcNext   = redirect_pc;
                            addrNext = redirect_pc;
                        end else begin
                            addrNext = pc;
                        end
                    end else begin
                        instrNext   = imem_rdata;
                        instrPcNext = addrQ;
                        validNext   = 1'b1;
                        reqNext     = 1'b0;
                        pcNext      = addrQ + STEP;
                        stateNext   = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay stable while the read is pending.
                    squashNext = 1'b1;
                    pcNext     = redirect_pc;
                end
            end
            HOLD: begin
                if (!stall) begin
                    validNext = 1'b0;
                    if (halt) begin
                        haltedNext = 1'b1;
                        stateNext  = HALTED;
                    end else if (redirect_valid) begin
                        pcNext    = redirect_pc;
                        reqNext   = 1'b1;
                        addrNext  = redirect_pc;
                        stateNext = REQ;
                    end else begin
                        reqNext   = 1'b1;
                        addrNext  = pc;
                        stateNext = REQ;
                    end
                end
            end
            HALTED: begin
                reqNext    = 1'b0;
                validNext  = 1'b0;
                haltedNext = 1'b1;
            end
            default: stateNext = REQ_START;
        endcase
    end

    assign imem_req    = reqQ;
    assign imem_addr   = addrQ;
    assign instr       = instrQ;
    assign instr_valid = validQ;
    assign instr_pc    = instrPcQ;
    assign halted      = haltedQ;

`ifdef FETCH_COUNT_EN
    logic        accept;
    logic [31:0] countQ;

    assign accept = (state == HOLD) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= '0;
        end else if (accept) begin
            countQ <= countQ + 32'd1;
        end
    end

    assign fetch_count = countQ;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage of the 32-bit core. It owns the PC, issues word reads to instruction memory over a req/valid handshake, and holds each fetched word in an instruction register. That register drives the instruction decoder directly. It consumes the decoder's halt, enable (stall) and branch-redirect results to stop, hold or retarget the PC.

Parameters:
ADDR_W, 16, width of PC and imem address
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per instruction (word addressing)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request, held until imem_valid
imem_addr  out  ADDR_W  read address, stable while imem_req=1
imem_rdata  in  32  read data, qualified by imem_valid
imem_valid  in  1  read complete; only meaningful while imem_req=1
stall  in  1  decoder not ready (inverse of decoder en); holds instr
halt  in  1  held instr is HALT; sampled at accept
redirect_valid  in  1  taken branch / PC write from the held instr
redirect_pc  in  ADDR_W  redirect target
instr  out  32  instruction register, feeds decoder I
instr_valid  out  1  instr holds a live instruction
instr_pc  out  ADDR_W  address of instr
halted  out  1  fetch permanently stopped
fetch_count  out  32  accepted-instruction counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state REQ_START; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr=0; instr_valid=0; instr_pc=RESET_PC; halted=0; squash=0; fetch_count=0.
- States: REQ_START, REQ, HOLD, HALTED. All outputs registered.
- REQ_START: first edge after reset release -> REQ with imem_req=1, imem_addr=pc.
- REQ: imem_req=1, imem_addr constant.
  - redirect_valid=1 without imem_valid: set squash, save redirect_pc as pc.
  - imem_valid=1 and (squash or redirect_valid): discard data; clear squash. imem_addr = redirect_pc if redirect_valid, else saved pc. Stay REQ (new request next cycle).
  - imem_valid=1, no squash/redirect: instr<=imem_rdata; instr_pc<=imem_addr; instr_valid<=1; imem_req<=0; pc<=imem_addr+PC_STEP; -> HOLD.
- HOLD: instr_valid=1; instr, instr_pc stable. Accept = stall=0. halt and redirect_valid are ignored while stall=1.
  - Accept with halt=1: instr_valid<=0; halted<=1; -> HALTED. halt has priority over redirect.
  - Accept with redirect_valid=1: instr_valid<=0; pc<=redirect_pc; imem_req<=1; imem_addr<=redirect_pc; -> REQ.
  - Accept otherwise: instr_valid<=0; imem_req<=1; imem_addr<=pc; -> REQ.
- HALTED: imem_req=0; instr_valid=0; halted=1; all inputs ignored until reset.
- Latency: an accept in cycle N gives imem_req=1 in cycle N+1. A memory response in cycle M gives instr_valid=1 in cycle M+1. Minimum 2 cycles per instruction with zero-wait memory.
- PC arithmetic: modulo 2^ADDR_W. (2^ADDR_W-1)+PC_STEP wraps to 0 silently.
- Reset mid-request: the request is abandoned and any late imem_valid is ignored. The memory must tolerate a req drop without valid.

Optional Feature:
FETCH_COUNT_EN
- Defined: fetch_count increments by 1 on every HOLD accept, halt instruction included. It wraps at 2^32 and resets to 0.
- Not defined: no counter register; fetch_count tied to 0.

Test Plan:
- Reset/boot, RESET_PC=0, memory returns 32'h1234_5678 one cycle after req -> imem_addr=0 on first req; instr=32'h1234_5678, instr_pc=0, instr_valid=1 one cycle after imem_valid; next req to addr 1 after accept.
- Stall: hold stall=1 for 5 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0 throughout. stall=0 -> req to pc+1 next cycle.
- Redirect at accept: held instr at pc 4, redirect_valid=1, redirect_pc=16'h0040 -> next imem_addr=16'h0040, instr_pc=16'h0040 after fetch.
- Squash: redirect_pc=16'h0020 pulsed while a 3-cycle memory read of addr 7 is pending -> addr-7 data discarded, instr_valid stays 0, next req to 16'h0020.
- Halt: accept with halt=1 and redirect_valid=1 -> halted=1, instr_valid=0, imem_req=0 forever. Later redirect/imem_valid have no effect; rst_n low restarts at RESET_PC.
- Wrap and count: pc=16'hFFFF fetch -> next req addr 0. With FETCH_COUNT_EN, 3 accepts -> fetch_count=3; without the macro -> fetch_count=0.
